mem_bridge_mc: RTL
==================

// Module: mem_bridge_mc
// PURPOSE
//  Memory-side stage of the multi-cycle core: takes one load/store per request from the datapath
//  (address, store data, funct3 size) and runs it on a valid/ready bus with variable latency.
//  Generates byte strobes and store lane replication, and sign/zero-extends load data.
//  Raises core_stall until the access completes, so the controller FSM holds its state.
//  Flags misaligned, illegal-size and timed-out accesses.
// PARAMETERS
//  TIMEOUT   255   max cycles waiting on bus_ready/bus_rvalid before abort (>=1)
//  CNT_W     8     width of timeout counter; must hold TIMEOUT
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  core_req    in   1   access request; held high by core while core_stall=1
//  core_we     in   1   1=store, 0=load (sampled at acceptance)
//  core_size   in   3   funct3 of load/store (sampled at acceptance)
//  core_addr   in   32  byte address (sampled at acceptance)
//  core_wdata  in   32  store data, low-aligned (sampled at acceptance)
//  core_rdata  out  32  extended load data; valid while state==DONE
//  core_stall  out  1   core_req & (state!=DONE)
//  core_err    out  1   error for completing access; valid while state==DONE
//  bus_valid   out  1   bus request valid
//  bus_ready   in   1   bus accepts request when bus_valid & bus_ready
//  bus_we      out  1   bus write
//  bus_addr    out  32  word address {addr[31:2],2'b00}
//  bus_wdata   out  32  lane-replicated store data
//  bus_wstrb   out  4   byte enables (0000 on reads)
//  bus_rvalid  in   1   read data valid
//  bus_rdata   in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs =0: bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
//   core_rdata, core_err, timeout counter. core_stall=0 is combinational.
//  States: IDLE, REQ, RESP, DONE (2-bit encoding).
//  IDLE: if core_req, latch all inputs and reset the counter.
//   - Illegal size -> DONE with err=1, no bus activity. Legal loads: 000 lb, 001 lh, 010 lw,
//     100 lbu, 101 lhu. Legal stores: 000, 001, 010.
//   - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with err=1, no bus activity.
//   - Otherwise -> REQ with bus_valid=1 on the next cycle.
//  REQ: bus_valid held with bus_addr, bus_we, bus_wdata and bus_wstrb stable until bus_ready.
//   - On bus_ready, bus_valid drops next cycle. A store goes to DONE (posted write).
//   - A load goes to RESP. If bus_rvalid is also high in the same cycle, the load goes to DONE
//     and captures bus_rdata.
//  RESP: on bus_rvalid, capture the extended bus_rdata -> DONE. bus_rvalid seen outside REQ/RESP
//   is ignored.
//  Timeout: the counter increments each cycle in REQ/RESP. When counter==TIMEOUT-1 and the
//   awaited handshake is absent -> DONE with err=1, core_rdata=0, bus_valid forced 0.
//  DONE: lasts exactly 1 cycle with stall=0 -> IDLE. A core_req still high in DONE is not
//   accepted until IDLE.
//   - Latency for a zero-wait read (ready and rvalid in the same cycle as REQ): accept, REQ,
//     DONE = stall for 2 cycles.
//  Store lanes:
//   - sb: wdata={4{b}}, wstrb=0001<<addr[1:0]
//   - sh: wdata={2{h}}, wstrb=0011<<addr[1:0]
//   - sw: wdata=word, wstrb=1111
//  Load extract: byte/half selected by latched addr[1:0]; sign-extend for 000/001, zero-extend
//   for 100/101.
//  Async reset mid-access: immediately IDLE with bus_valid=0; any bus response in flight is dropped.
//  core_err is held 0 for successful accesses.
// STRUCTURE
//  mem_defs.vh: localparams for the funct3 size codes (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the
//   state encoding; shared with the instruction decoder.
//  One sub-module, load_extender (combinational): in bus_rdata, addr[1:0], size -> out 32-bit
//   extended data.
//  Top: FSM, timeout counter, request/response registers, store lane logic.
// TESTING
//  1 lw addr 0x100, ready at cycle 1, rvalid 3 cycles later with 0xDEADBEEF
//    -> rdata=0xDEADBEEF, err=0, bus_valid held until ready.
//  2 lb addr 0x103, rdata 0x80_00_00_00 -> core_rdata=0xFFFFFF80; lbu same -> 0x00000080.
//  3 sh addr 0x202 wdata 0x0000ABCD -> bus_wdata=0xABCDABCD, wstrb=1100, no RESP state, err=0.
//  4 lw addr 0x101 -> DONE next cycle, err=1, bus_valid never asserted.
//  5 TIMEOUT=4, lw with bus_ready never high -> err=1 and rdata=0 after 4 REQ cycles,
//    bus_valid drops.
//  6 rst asserted while in RESP -> outputs 0 asynchronously; a later rvalid is ignored;
//    a new lw completes normally.

Source files
------------

// File: rtl/mem_bridge_mc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_bridge_mc_pkg : size codes, state encoding, store-lane helpers    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package mem_bridge_mc_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic size_legal(input logic we, input logic [2:0] size);
        logic ok;
        ok = (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
        if (!we) begin
            ok = ok || (size == SZ_BU) || (size == SZ_HU);
        end
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        return ((size[1:0] == 2'b01) && addr_lo[0]) ||
               ((size[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << addr_lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wdata);
        case (size[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bridge_mc_load_extender.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_bridge_mc_load_extender : byte/half select and sign/zero extend   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module mem_bridge_mc_load_extender
    import mem_bridge_mc_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_B:    data = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   data = {24'd0, byte_sel};
            SZ_H:    data = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bridge_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_bridge_mc : multi-cycle load/store bridge onto a valid/ready bus  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module mem_bridge_mc
    import mem_bridge_mc_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       size_q;
    logic [1:0]       addr_lo_q;
    logic             we_q;
    logic [31:0]      ext_data;

    logic req_bad;
    logic timeout_hit;
    logic accept;
    logic capture;
    logic abort;

    assign req_bad     = !size_legal(core_we, core_size) || misaligned(core_size, core_addr[1:0]);
    assign timeout_hit = (cnt == TMO_LAST);

    mem_bridge_mc_load_extender u_ext (
        .rdata   (bus_rdata),
        .addr_lo (addr_lo_q),
        .size    (size_q),
        .data    (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (core_req) begin
                    state_nxt = req_bad ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // Stores are posted; a load whose data arrives with ready skips RESP.
                if (bus_ready) begin
                    state_nxt = (we_q || bus_rvalid) ? ST_DONE : ST_RESP;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RESP: begin
                if (bus_rvalid || timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        core_stall = core_req && (state != ST_DONE);
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: accept = core_req;
            ST_REQ: begin
                capture = bus_ready && !we_q && bus_rvalid;
                abort   = !bus_ready && timeout_hit;
            end
            ST_RESP: begin
                capture = bus_rvalid;
                abort   = !bus_rvalid && timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            size_q     <= 3'd0;
            addr_lo_q  <= 2'd0;
            we_q       <= 1'b0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_wstrb  <= 4'd0;
            core_rdata <= 32'd0;
            core_err   <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            size_q     <= core_size;
            addr_lo_q  <= core_addr[1:0];
            we_q       <= core_we;
            core_err   <= req_bad;
            core_rdata <= 32'd0;
            if (!req_bad) begin
                bus_valid <= 1'b1;
                bus_we    <= core_we;
                bus_addr  <= {core_addr[31:2], 2'b00};
                bus_wdata <= core_we ? store_lanes(core_size, core_wdata) : 32'd0;
                bus_wstrb <= core_we ? store_strb(core_size, core_addr[1:0]) : 4'd0;
            end
        end else if ((state == ST_REQ) || (state == ST_RESP)) begin
            cnt <= cnt + 1'b1;
            if ((state == ST_REQ) && bus_ready) begin
                bus_valid <= 1'b0;
            end
            if (capture) begin
                core_rdata <= ext_data;
                core_err   <= 1'b0;
            end
            if (abort) begin
                bus_valid  <= 1'b0;
                core_err   <= 1'b1;
                core_rdata <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire
